// File: rtl/fpu_pkg.sv
// fpu_pkg: IEEE-754 format widths, bias and operand class indices shared by the FPU blocks
package fpu_pkg;
  function automatic int fpu_exp_width(input int b);
    return b == 16 ? 5 : b == 32 ? 8 : b == 64 ? 11 : 15;
  endfunction
  function automatic int fpu_frac_width(input int b);
    return b == 16 ? 10 : b == 32 ? 23 : b == 64 ? 52 : 112;
  endfunction
  function automatic int fpu_bias(input int b);
    return (1 << (fpu_exp_width(b) - 1)) - 1;
  endfunction
  localparam int FPU_CLS_ZERO = 0;
  localparam int FPU_CLS_SUB  = 1;
  localparam int FPU_CLS_NORM = 2;
  localparam int FPU_CLS_INF  = 3;
  localparam int FPU_CLS_QNAN = 4;
  localparam int FPU_CLS_SNAN = 5;
endpackage

// File: rtl/lzc.sv
// lzc: combinational leading-zero counter, returns WIDTH for an all-zero input
module lzc #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] in_i,
  output logic [CW-1:0]    cnt_o
);
  // scan upward so the highest set bit is the last one to set the count
  always_comb begin
    cnt_o = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) if (in_i[i]) cnt_o = CW'(WIDTH - 1 - i);
  end
endmodule

// File: rtl/fpu_unpack_pipe.sv
// fpu_unpack_pipe: two-stage IEEE operand unpacker (classify, then normalise) with valid/ready
module fpu_unpack_pipe
  import fpu_pkg::*;
#(
  parameter int BITNESS = 32,
  localparam int EW = fpu_exp_width(BITNESS),
  localparam int FW = fpu_frac_width(BITNESS),
  localparam int BIAS = fpu_bias(BITNESS),
  localparam int XW = EW + 2
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BITNESS-1:0] in_number,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_sign,
  output logic [XW-1:0]      out_exp,
  output logic [FW:0]        out_mant,
  output logic [5:0]         out_class
);
  localparam int LW = $clog2(FW + 1);
  if (BITNESS != 16 && BITNESS != 32 && BITNESS != 64 && BITNESS != 128) begin : g_bad_bitness
    $error("fpu_unpack_pipe: BITNESS must be 16, 32, 64 or 128");
  end
  logic [EW-1:0] e;
  logic [FW-1:0] f;
  logic          e_zero, e_ones, f_zero;
  logic [5:0]    cls;
  logic [LW-1:0] lz;
  logic          s1_valid_q, s1_sign_q, s2_ready;
  logic [EW-1:0] s1_exp_q;
  logic [FW-1:0] s1_frac_q;
  logic [5:0]    s1_class_q;
  logic [LW-1:0] s1_lz_q;
  logic [FW:0]   mant_d;
  logic [XW-1:0] exp_d;
  assign e      = in_number[BITNESS-2 -: EW];
  assign f      = in_number[FW-1:0];
  assign e_zero = e == '0;
  assign e_ones = &e;
  assign f_zero = f == '0;
  // one-hot operand class from the raw exponent/fraction fields
  always_comb begin
    cls               = '0;
    cls[FPU_CLS_ZERO] = e_zero && f_zero;
    cls[FPU_CLS_SUB]  = e_zero && !f_zero;
    cls[FPU_CLS_NORM] = !e_zero && !e_ones;
    cls[FPU_CLS_INF]  = e_ones && f_zero;
    cls[FPU_CLS_QNAN] = e_ones && f[FW-1];
    cls[FPU_CLS_SNAN] = e_ones && !f_zero && !f[FW-1];
  end
  lzc #(.WIDTH(FW)) u_lzc (.in_i(f), .cnt_o(lz));
  // stage 2 can take a new entry when empty or when its result leaves this cycle
  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid_q || s2_ready;
  // subnormal exponent 1-BIAS-(lz+1) folds to -BIAS-lz
  always_comb begin
    mant_d = s1_class_q[FPU_CLS_SUB] ? ({1'b0, s1_frac_q} << s1_lz_q) << 1
           : (s1_class_q[FPU_CLS_NORM] || s1_class_q[FPU_CLS_QNAN] || s1_class_q[FPU_CLS_SNAN]) ? {1'b1, s1_frac_q}
           : '0;
    exp_d  = s1_class_q[FPU_CLS_NORM] ? XW'(s1_exp_q) - XW'(BIAS)
           : s1_class_q[FPU_CLS_SUB] ? XW'(0) - XW'(BIAS) - XW'(s1_lz_q)
           : '0;
  end
  // stage 1: capture fields, class and leading-zero count on input handshake
  always_ff @(posedge clk) begin
    if (reset) s1_valid_q <= 1'b0;
    else if (in_ready) begin
      s1_valid_q <= in_valid;
      if (in_valid) {s1_sign_q, s1_exp_q, s1_frac_q, s1_class_q, s1_lz_q} <= {in_number[BITNESS-1], e, f, cls, lz};
    end
  end
  // stage 2: normalise and drive the registered outputs, holding them while stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_sign  <= 1'b0;
      out_exp   <= '0;
      out_mant  <= '0;
      out_class <= '0;
    end else if (s2_ready) begin
      out_valid <= s1_valid_q;
      if (s1_valid_q) {out_sign, out_exp, out_mant, out_class} <= {s1_sign_q, exp_d, mant_d, s1_class_q};
    end
  end
endmodule

// File: tb/tb_fpu_unpack_pipe.sv
// tb_fpu_unpack_pipe: directed tables, backpressure scoreboard, reset-under-stall and width sweep
module tb_fpu_unpack_pipe;
  typedef struct {
    logic [31:0] n;
    logic        s;
    int          e;
    logic [23:0] m;
    logic [5:0]  c;
  } vec_t;
  typedef struct {
    logic         s;
    longint       e;
    logic [127:0] m;
    logic [5:0]   c;
    int           cyc;
  } sb_t;
  logic        clk = 1'b0, reset, iv, ir, ov, ordy, os, chk_lat, fired, sweep_go;
  logic [31:0] num;
  logic [9:0]  oe;
  logic [23:0] om;
  logic [5:0]  oc;
  int          checks = 0, errors = 0, cyc = 0;
  sb_t         q32[$];
  sb_t         exp_next;
  logic        stall_prev, p_s;
  logic [9:0]  p_e;
  logic [23:0] p_m;
  logic [5:0]  p_c;
  vec_t        tbl[12];
  always #5 clk = ~clk;
  fpu_unpack_pipe #(.BITNESS(32)) dut (
    .clk(clk), .reset(reset), .in_valid(iv), .in_ready(ir), .in_number(num),
    .out_valid(ov), .out_ready(ordy), .out_sign(os), .out_exp(oe), .out_mant(om), .out_class(oc)
  );
  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, got, want);
    end
  endtask
  task automatic model(input int b, input logic [127:0] n, output sb_t r);
    int ew, fw, bias, emax, ex;
    logic [127:0] f;
    ew   = b == 16 ? 5 : b == 32 ? 8 : b == 64 ? 11 : 15;
    fw   = b == 16 ? 10 : b == 32 ? 23 : b == 64 ? 52 : 112;
    bias = (1 << (ew - 1)) - 1;
    emax = (1 << ew) - 1;
    f    = n & ((128'(1) << fw) - 128'(1));
    ex   = int'((n >> fw) & 128'(emax));
    r.s = n[b-1]; r.e = 0; r.m = '0; r.c = '0; r.cyc = 0;
    if (ex == 0 && f == 0) r.c = 6'b000001;
    else if (ex == 0) begin
      r.c = 6'b000010; r.m = f; r.e = 1 - bias;
      while (!r.m[fw]) begin r.m = r.m << 1; r.e--; end
    end else if (ex == emax) begin
      r.m = f == 0 ? '0 : f | (128'(1) << fw);
      r.c = f == 0 ? 6'b001000 : f[fw-1] ? 6'b010000 : 6'b100000;
    end else begin
      r.c = 6'b000100; r.m = f | (128'(1) << fw); r.e = ex - bias;
    end
  endtask
  function automatic logic [127:0] gen(input int b);
    int ew, fw, emax, cls, ex;
    logic [127:0] f;
    ew   = b == 16 ? 5 : b == 32 ? 8 : b == 64 ? 11 : 15;
    fw   = b == 16 ? 10 : b == 32 ? 23 : b == 64 ? 52 : 112;
    emax = (1 << ew) - 1;
    f    = {$urandom, $urandom, $urandom, $urandom} & ((128'(1) << fw) - 128'(1));
    cls  = $urandom_range(0, 5);
    ex   = cls == 2 ? int'($urandom_range(1, emax - 1)) : cls >= 3 ? emax : 0;
    if (cls == 0 || cls == 3) f = '0;
    if (cls == 4) f[fw-1] = 1'b1;
    if (cls == 5) f[fw-1] = 1'b0;
    if ((cls == 1 || cls == 5) && f == 0) f = 128'(1);
    return (128'($urandom_range(0, 1)) << (b - 1)) | (128'(ex) << fw) | f;
  endfunction
  task automatic newop32();
    logic [127:0] t;
    t = gen(32);
    num = t[31:0];
    model(32, t, exp_next);
  endtask
  task automatic drain();
    for (int t = 0; t < 50 && q32.size() != 0; t++) @(negedge clk);
    chk("drain_empty", 128'(q32.size()), 0);
  endtask
  // scoreboard for the 32-bit unit: order, values, latency, stall stability, in_ready
  always @(negedge clk) begin
    sb_t h;
    cyc++;
    if (reset) begin
      q32.delete();
      stall_prev = 1'b0;
      fired = 1'b0;
    end else begin
      chk("in_ready", ir, !(q32.size() == 2 && !ordy));
      if (stall_prev) begin
        chk("stall_valid", ov, 1);
        chk("stall_sign", os, p_s);
        chk("stall_exp", oe, p_e);
        chk("stall_mant", om, p_m);
        chk("stall_class", oc, p_c);
      end
      if (ov && ordy) begin
        if (q32.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          h = q32.pop_front();
          chk("sign", os, h.s);
          chk("exp", 128'($signed(oe)), 128'(h.e));
          chk("mant", om, h.m);
          chk("class", oc, h.c);
          if (chk_lat) chk("latency", 128'(cyc - h.cyc), 2);
        end
      end
      fired = iv && ir;
      if (fired) begin
        h = exp_next;
        h.cyc = cyc;
        q32.push_back(h);
      end
      stall_prev = ov && !ordy;
      {p_s, p_e, p_m, p_c} = {os, oe, om, oc};
    end
  end
  // width sweep: one instance per other legal BITNESS, streaming with out_ready held high
  for (genvar k = 0; k < 3; k++) begin : g
    localparam int B = k == 0 ? 16 : k == 1 ? 64 : 128;
    localparam int FW = k == 0 ? 10 : k == 1 ? 52 : 112;
    localparam int XW = (k == 0 ? 5 : k == 1 ? 11 : 15) + 2;
    localparam longint MINE = k == 0 ? -24 : k == 1 ? -1074 : -16494;
    localparam logic [127:0] ONE = k == 0 ? 128'h3C00 : k == 1 ? 128'h3FF0_0000_0000_0000
                                 : 128'h3FFF_0000_0000_0000_0000_0000_0000_0000;
    logic v, rdy, ov_k, os_k, done;
    logic [B-1:0]  n;
    logic [XW-1:0] oe_k;
    logic [FW:0]   om_k;
    logic [5:0]    oc_k;
    sb_t q[$];
    fpu_unpack_pipe #(.BITNESS(B)) u (
      .clk(clk), .reset(reset), .in_valid(v), .in_ready(rdy), .in_number(n),
      .out_valid(ov_k), .out_ready(1'b1), .out_sign(os_k), .out_exp(oe_k), .out_mant(om_k), .out_class(oc_k)
    );
    initial begin
      sb_t x;
      logic [127:0] full;
      v = 1'b0; n = '0; done = 1'b0;
      wait (sweep_go);
      for (int i = 0; i < 202; i++) begin
        @(posedge clk); #1;
        if (i == 0) begin
          full = 128'(1); x.s = 0; x.e = MINE; x.m = 128'(1) << FW; x.c = 6'b000010;
        end else if (i == 1) begin
          full = ONE; x.s = 0; x.e = 0; x.m = 128'(1) << FW; x.c = 6'b000100;
        end else begin
          full = gen(B);
          model(B, full, x);
        end
        v = 1'b1;
        n = full[B-1:0];
        q.push_back(x);
      end
      @(posedge clk); #1 v = 1'b0;
      for (int t = 0; t < 20 && q.size() != 0; t++) @(negedge clk);
      chk($sformatf("sweep%0d_empty", B), 128'(q.size()), 0);
      done = 1'b1;
    end
    always @(negedge clk) begin
      sb_t h;
      if (!reset && v) chk($sformatf("sweep%0d_in_ready", B), rdy, 1);
      if (!reset && ov_k) begin
        if (q.size() == 0) chk($sformatf("sweep%0d_unexpected", B), 1, 0);
        else begin
          h = q.pop_front();
          chk($sformatf("sweep%0d_sign", B), os_k, h.s);
          chk($sformatf("sweep%0d_exp", B), 128'($signed(oe_k)), 128'(h.e));
          chk($sformatf("sweep%0d_mant", B), om_k, h.m);
          chk($sformatf("sweep%0d_class", B), oc_k, h.c);
        end
      end
    end
  end
  initial begin
    #600000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end
  initial begin
    int sent, guard;
    tbl[0]  = '{32'h3F800000, 1'b0,    0, 24'h800000, 6'b000100};
    tbl[1]  = '{32'h7F7FFFFF, 1'b0,  127, 24'hFFFFFF, 6'b000100};
    tbl[2]  = '{32'h00000001, 1'b0, -149, 24'h800000, 6'b000010};
    tbl[3]  = '{32'h00400000, 1'b0, -127, 24'h800000, 6'b000010};
    tbl[4]  = '{32'h80000000, 1'b1,    0, 24'h000000, 6'b000001};
    tbl[5]  = '{32'h7F800000, 1'b0,    0, 24'h000000, 6'b001000};
    tbl[6]  = '{32'h7FC00000, 1'b0,    0, 24'hC00000, 6'b010000};
    tbl[7]  = '{32'h7F800001, 1'b0,    0, 24'h800001, 6'b100000};
    tbl[8]  = '{32'hC0490FDB, 1'b1,    1, 24'hC90FDB, 6'b000100};
    tbl[9]  = '{32'h00800000, 1'b0, -126, 24'h800000, 6'b000100};
    tbl[10] = '{32'h807FFFFF, 1'b1, -127, 24'hFFFFFE, 6'b000010};
    tbl[11] = '{32'hFFFFFFFF, 1'b1,    0, 24'hFFFFFF, 6'b010000};
    reset = 1'b1; iv = 1'b0; num = '0; ordy = 1'b1; chk_lat = 1'b0; sweep_go = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_valid", ov, 0); chk("rst_sign", os, 0); chk("rst_exp", oe, 0);
    chk("rst_mant", om, 0); chk("rst_class", oc, 0); chk("rst_in_ready", ir, 1);
    chk_lat = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      iv = 1'b1;
      num = tbl[i].n;
      exp_next.s = tbl[i].s; exp_next.e = tbl[i].e; exp_next.m = 128'(tbl[i].m); exp_next.c = tbl[i].c;
    end
    @(posedge clk); #1 iv = 1'b0;
    drain();
    chk_lat = 1'b0;
    sent = 0; guard = 0;
    while (sent < 1000 && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
      if (fired) sent++;
      ordy = $urandom_range(0, 1) == 1;
      if (fired || !iv) begin
        if (sent < 1000 && $urandom_range(0, 3) != 0) begin newop32(); iv = 1'b1; end
        else iv = 1'b0;
      end
    end
    chk("random_sent", 128'(sent), 1000);
    iv = 1'b0; ordy = 1'b1;
    drain();
    ordy = 1'b0; iv = 1'b1; newop32();
    for (int t = 0; t < 10; t++) begin
      @(posedge clk); #1;
      if (fired) newop32();
    end
    @(negedge clk);
    chk("full_stall_in_ready", ir, 0);
    chk("full_stall_valid", ov, 1);
    @(posedge clk); #1 reset = 1'b1; iv = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", ov, 0); chk("mid_rst_sign", os, 0); chk("mid_rst_exp", oe, 0);
    chk("mid_rst_mant", om, 0); chk("mid_rst_class", oc, 0); chk("mid_rst_in_ready", ir, 1);
    chk_lat = 1'b1; ordy = 1'b1;
    @(posedge clk); #1 iv = 1'b1; num = tbl[2].n;
    exp_next.s = tbl[2].s; exp_next.e = tbl[2].e; exp_next.m = 128'(tbl[2].m); exp_next.c = tbl[2].c;
    @(posedge clk); #1 iv = 1'b0;
    @(negedge clk); chk("post_rst_not_yet", ov, 0);
    drain();
    chk_lat = 1'b0;
    sweep_go = 1'b1;
    for (int t = 0; t < 3000 && !(g[0].done && g[1].done && g[2].done); t++) @(posedge clk);
    chk("sweep_done", {g[0].done, g[1].done, g[2].done}, 3'b111);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fpu_unpack_pipe.md
# fpu_unpack_pipe

Parametrised, two-stage pipelined floating-point unpacker for IEEE-754 binary16/32/64/128 operands. It splits an operand into sign, unbiased exponent and explicit-leading-bit mantissa. It classifies the operand and normalises subnormals so that downstream FPU datapaths see a uniform format. It sits between operand fetch and the FPU arithmetic stages, with valid/ready handshakes on both sides.

## Interface
- `BITNESS`, 32, operand width; legal values 16, 32, 64, 128 (others: elaboration error).
- Derived: EW = 5/8/11/15; FW = 10/23/52/112; BIAS = 2^(EW-1)-1; XW = EW+2.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  operand present.
- `in_ready`  out  1  unit accepts operand this cycle.
- `in_number`  in  BITNESS  packed IEEE operand.
- `out_valid`  out  1  result present.
- `out_ready`  in  1  consumer accepts result.
- `out_sign`  out  1  sign bit.
- `out_exp`  out  XW  signed two's-complement unbiased exponent.
- `out_mant`  out  FW+1  mantissa with explicit leading bit.
- `out_class`  out  6  one-hot: [0] zero, [1] subnormal, [2] normal, [3] inf, [4] qnan, [5] snan.

## Operation
- Let E = exponent field and F = fraction field.
- Normal (0<E<all-ones):
  - `out_exp` = E-BIAS.
  - `out_mant` = {1,F}.
- Subnormal (E=0, F≠0):
  - lz = leading zeros of F (FW-bit).
  - `out_mant` = {0,F} << (lz+1); MSB is always 1.
  - `out_exp` = 1-BIAS-(lz+1).
- Zero (E=0, F=0): `out_exp`=0, `out_mant`=0.
- Inf (E=all-ones, F=0): `out_exp`=0, `out_mant`=0.
- NaN (E=all-ones, F≠0): `out_exp`=0, `out_mant`={1,F}. F MSB=1 gives qnan; F MSB=0 gives snan.
- Sign passes through unchanged in all classes, including NaN and zero.
- Stage 1 (registered): capture sign, E, F, class, and lz (from `lzc` on F).
- Stage 2 (registered): apply the shift and the exponent adjust, then drive the outputs.
- XW is sized so the minimum subnormal exponent never overflows.

## Timing
- Latency: 2 cycles from an input handshake to `out_valid`, when unstalled.
- Throughput: 1 operand/cycle sustained.
- Handshake:
  - Input transfer occurs when `in_valid`&&`in_ready`.
  - Output transfer occurs when `out_valid`&&`out_ready`.
  - `in_ready` = !s1_valid || !s2_valid || `out_ready`. It is combinational from `out_ready`; there is no combinational in→out path.
- Stall: while `out_valid`&&!`out_ready`, all `out_*` hold stable.
  - Stage 1 is filled if empty; otherwise it holds.
  - No operand is lost or duplicated.
- Simultaneous events: an input accept, stage advance and output accept in the same cycle must all occur; pipeline occupancy stays constant.
- Reset (synchronous, any cycle including mid-stall):
  - Next edge clears both valid bits and drops in-flight operands.
  - `out_valid`=0, `out_sign`=0, `out_exp`=0, `out_mant`=0, `out_class`=0.
  - `in_ready`=1 from the first cycle after reset.
- `in_number` is ignored when `in_valid`=0. The outputs are meaningful only while `out_valid`=1.

## Structure
- Package `fpu_pkg` holds:
  - Width functions `fpu_exp_width(b)` and `fpu_frac_width(b)`, and bias function `fpu_bias(b)`.
  - Class index constants `FPU_CLS_ZERO..FPU_CLS_SNAN`.
- Sub-module `lzc` (parameter `WIDTH`) is a combinational leading-zero counter, reused later by normalise/round. It returns WIDTH on all-zero input.
- Top module: two pipeline register banks plus handshake logic, 120–250 lines.

## Test plan
- BITNESS=32, back-to-back stream with `out_ready`=1:
  - 0x3F800000 → sign 0, exp 0, mant 0x800000, class normal.
  - 0x7F7FFFFF → exp 127, mant 0xFFFFFF.
  - Results arrive 2 cycles after input, one per cycle.
- Subnormals at BITNESS=32:
  - 0x00000001 → exp -149, mant 0x800000, class subnormal.
  - 0x00400000 → exp -127, mant 0x800000.
- Specials at BITNESS=32:
  - 0x80000000 → sign 1, class zero, exp 0, mant 0.
  - 0x7F800000 → inf.
  - 0x7FC00000 → qnan.
  - 0x7F800001 → snan, mant 0x800001.
- Backpressure: random `out_ready` and `in_valid` over 1000 operands. Expect order preserved, no drops or duplicates, outputs stable during stall, `in_ready`=0 only when both stages are full and `out_ready`=0.
- Reset while the pipeline is full and stalled. Expect next-cycle `out_valid`=0, all outputs 0, `in_ready`=1, and the first post-reset operand out after 2 cycles.
- Parameter sweep (16/64/128): compare against a reference model using 0x0001, 0x3C00 (binary16) and 0x0000000000000001 (binary64, exp -1074). Also run randomised operands with all classes weighted equally.
